// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the width helper for the shift counter.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Counter has to represent 0..stages inclusive.
    function automatic int CNT_W(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/usr_stage.sv
// One LANES-wide stage of the universal shift register with its 4:1 input
// mux (hold / lower neighbour / upper neighbour / parallel slice).
module usr_stage
    import usr_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [LANES-1:0] from_lower,
    input  logic [LANES-1:0] from_upper,
    input  logic [LANES-1:0] load_val,
    output logic [LANES-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_SHR:  q <= from_lower;
                MODE_SHL:  q <= from_upper;
                MODE_LOAD: q <= load_val;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register with word framing: counts shifts
// since the last LOAD/reset and flags a complete word.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int LANES  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [LANES-1:0]        sin,
    input  logic [STAGES*LANES-1:0] pin,
    output logic [LANES-1:0]        sout_r,
    output logic [LANES-1:0]        sout_l,
    output logic [STAGES*LANES-1:0] pout,
    output logic                    word_full,
    output logic                    word_done
);

    localparam int CW = CNT_W(STAGES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STAGES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STAGES - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("univ_shift_reg: STAGES must be at least 2");
    end

    logic [LANES-1:0] stage_q [STAGES];
    logic [CW-1:0]    cnt;
    logic             shift_en;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [LANES-1:0] lower;
        logic [LANES-1:0] upper;

        // End stages take sin where the neighbour would be.
        if (i == 0) begin : g_first
            assign lower = sin;
        end else begin : g_mid_lo
            assign lower = stage_q[i-1];
        end

        if (i == STAGES - 1) begin : g_last
            assign upper = sin;
        end else begin : g_mid_hi
            assign upper = stage_q[i+1];
        end

        usr_stage #(.LANES(LANES)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .mode       (mode),
            .from_lower (lower),
            .from_upper (upper),
            .load_val   (pin[i*LANES +: LANES]),
            .q          (stage_q[i])
        );

        assign pout[i*LANES +: LANES] = stage_q[i];
    end

    assign sout_r = stage_q[STAGES-1];
    assign sout_l = stage_q[0];

    assign shift_en = (mode == MODE_SHR) || (mode == MODE_SHL);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            word_full <= 1'b0;
            word_done <= 1'b0;
        end else if (mode == MODE_LOAD) begin
            cnt       <= '0;
            word_full <= 1'b0;
            word_done <= 1'b0;
        end else if (shift_en) begin
            word_done <= (cnt == CNT_PRE);
            if (cnt == CNT_PRE) begin
                word_full <= 1'b1;
            end
            // Saturate so post-word shifts never re-pulse word_done.
            if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: a word-level arithmetic model feeds
// expected outputs into a queue that a separate monitor drains and compares.
module tb_univ_shift_reg;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHR  = 2'b01;
    localparam logic [1:0] SHL  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 4 x 1 instance
    logic       rst = 1'b1;
    logic [1:0] mode = HOLD;
    logic       sin = 1'b0;
    logic [3:0] pin = '0;
    logic       sout_r, sout_l, word_full, word_done;
    logic [3:0] pout;

    // 3 x 8 instance
    logic        rst8 = 1'b1;
    logic [1:0]  mode8 = HOLD;
    logic [7:0]  sin8 = '0;
    logic [23:0] pin8 = '0;
    logic [7:0]  sout_r8, sout_l8;
    logic [23:0] pout8;
    logic        word_full8, word_done8;

    univ_shift_reg #(.STAGES(4), .LANES(1)) u_dut4 (
        .clk(clk), .rst(rst), .mode(mode), .sin(sin), .pin(pin),
        .sout_r(sout_r), .sout_l(sout_l), .pout(pout),
        .word_full(word_full), .word_done(word_done)
    );

    univ_shift_reg #(.STAGES(3), .LANES(8)) u_dut8 (
        .clk(clk), .rst(rst8), .mode(mode8), .sin(sin8), .pin(pin8),
        .sout_r(sout_r8), .sout_l(sout_l8), .pout(pout8),
        .word_full(word_full8), .word_done(word_done8)
    );

    typedef struct {
        int pout;
        int sout_r;
        int sout_l;
        int full;
        int done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: the whole register as one integer (stage i at bit i),
    // plus an unbounded count of shifts since the last LOAD/reset.
    int word_m   = 0;
    int shifts_m = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic r, input logic [1:0] m, input logic s,
                         input logic [3:0] p);
        exp_t e;
        int   done;
        rst  = r;
        mode = m;
        sin  = s;
        pin  = p;
        done = 0;
        if (r) begin
            word_m   = 0;
            shifts_m = 0;
        end else begin
            case (m)
                SHR: begin
                    word_m = ((word_m * 2) + int'(s)) % 16;
                    shifts_m++;
                    done = (shifts_m == 4);
                end
                SHL: begin
                    word_m = (word_m / 2) + int'(s) * 8;
                    shifts_m++;
                    done = (shifts_m == 4);
                end
                LOAD: begin
                    word_m   = int'(p);
                    shifts_m = 0;
                end
                default: ;
            endcase
        end
        e.pout   = word_m;
        e.sout_r = (word_m / 8) % 2;
        e.sout_l = word_m % 2;
        e.full   = (shifts_m >= 4) ? 1 : 0;
        e.done   = done;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pout",      int'(pout),      e.pout);
                check("sout_r",    int'(sout_r),    e.sout_r);
                check("sout_l",    int'(sout_l),    e.sout_l);
                check("word_full", int'(word_full), e.full);
                check("word_done", int'(word_done), e.done);
            end
        end
    end

    task automatic apply8(input logic r, input logic [1:0] m, input logic [7:0] s);
        rst8  = r;
        mode8 = m;
        sin8  = s;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [1:0] rm;
        @(posedge clk);
        #2;

        // Reset overrides LOAD
        apply(1'b1, LOAD, 1'b0, 4'hF);

        // SISO, then flush to see the rest on sout_r and post-saturation shifts
        apply(1'b0, SHR, 1'b1, 4'h0);
        apply(1'b0, SHR, 1'b0, 4'h0);
        apply(1'b0, SHR, 1'b1, 4'h0);
        apply(1'b0, SHR, 1'b1, 4'h0);
        for (int i = 0; i < 4; i++) apply(1'b0, SHR, 1'b0, 4'h0);

        // PISO via SHL; LOAD while full clears word_full
        apply(1'b0, LOAD, 1'b0, 4'b1010);
        for (int i = 0; i < 4; i++) apply(1'b0, SHL, 1'b0, 4'h0);
        apply(1'b0, HOLD, 1'b1, 4'h0);

        // SIPO with stalls
        apply(1'b1, HOLD, 1'b0, 4'h0);
        apply(1'b0, SHR, 1'b1, 4'h0);
        for (int i = 0; i < 3; i++) apply(1'b0, HOLD, 1'b0, 4'h0);
        apply(1'b0, SHR, 1'b0, 4'h0);
        apply(1'b0, SHR, 1'b1, 4'h0);
        apply(1'b0, SHR, 1'b1, 4'h0);
        apply(1'b0, HOLD, 1'b0, 4'h0);

        // LOAD in place of the saturating shift, then rst mid-word
        apply(1'b1, HOLD, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) apply(1'b0, SHL, 1'b1, 4'h0);
        apply(1'b0, LOAD, 1'b0, 4'h6);
        apply(1'b0, SHR, 1'b1, 4'h0);
        apply(1'b0, SHL, 1'b0, 4'h0);
        apply(1'b1, SHR, 1'b1, 4'h0);
        for (int i = 0; i < 5; i++) apply(1'b0, (i % 2 == 0) ? SHR : SHL, 1'b1, 4'h0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rm = 2'($urandom_range(0, 3));
            apply(($urandom_range(0, 24) == 0), rm, 1'($urandom),
                  4'($urandom));
        end
        apply(1'b0, HOLD, 1'b0, 4'h0);
        @(posedge clk);
        #3;
        check("sb_drain", sb.size(), 0);

        // Wide-lane instance: 3 stages x 8 bits
        apply8(1'b1, HOLD, 8'h00);
        check("w8_rst_pout", int'(pout8), 0);
        check("w8_rst_full", int'(word_full8), 0);
        apply8(1'b0, SHR, 8'hA5);
        apply8(1'b0, SHR, 8'h3C);
        check("w8_done_early", int'(word_done8), 0);
        apply8(1'b0, SHR, 8'hFF);
        check("w8_pout",   int'(pout8),      int'(24'hA53CFF));
        check("w8_sout_r", int'(sout_r8),    int'(8'hA5));
        check("w8_sout_l", int'(sout_l8),    int'(8'hFF));
        check("w8_done",   int'(word_done8), 1);
        check("w8_full",   int'(word_full8), 1);
        apply8(1'b0, HOLD, 8'h00);
        check("w8_done_pulse", int'(word_done8), 0);
        check("w8_hold_pout",  int'(pout8),      int'(24'hA53CFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
